// File: rtl/regfile_warb_pkg.sv
// Shared widths, request type and constants for the register-file write-port arbiter.
package regfile_warb_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned NUM_REQ    = 2;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wreq_t;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Requester handshakes, regfile write port, pending mask and stall counters of the arbiter.
interface regfile_wport_arbiter_if
    import regfile_warb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);

    logic                   req0_val;
    logic                   req0_rdy;
    logic [ADDR_W-1:0]      req0_addr;
    logic [DATA_W-1:0]      req0_data;
    logic                   req1_val;
    logic                   req1_rdy;
    logic [ADDR_W-1:0]      req1_addr;
    logic [DATA_W-1:0]      req1_data;
    logic                   wen;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic [(1<<ADDR_W)-1:0] pend;
    logic [CNT_W-1:0]       stall0_cnt;
    logic [CNT_W-1:0]       stall1_cnt;

    modport master (
        output req0_val, req0_addr, req0_data, req1_val, req1_addr, req1_data,
        input  req0_rdy, req1_rdy, wen, waddr, wdata, pend, stall0_cnt, stall1_cnt
    );

    modport slave (
        input  req0_val, req0_addr, req0_data, req1_val, req1_addr, req1_data,
        output req0_rdy, req1_rdy, wen, waddr, wdata, pend, stall0_cnt, stall1_cnt
    );

endinterface

// File: rtl/regfile_warb_slot.sv
// One-entry holding slot for a writeback requester: capture, release on grant, pend decode.
module regfile_warb_slot
    import regfile_warb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   val_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic                   grant_i,
    output logic                   rdy_o,
    output logic                   vld_o,
    output logic                   live_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [(1<<ADDR_W)-1:0] pend_o
);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              cap;

    // Slot frees in the cycle it is granted, so a lone requester streams at 1/cycle.
    assign rdy_o  = !vld_q || grant_i;
    assign cap    = val_i && rdy_o;
    assign vld_o  = vld_q;
    assign live_o = vld_q && (addr_q != ADDR_W'(REG_ZERO));
    assign addr_o = addr_q;
    assign data_o = data_q;

    always_comb begin
        vld_d = vld_q;
        if (grant_i) vld_d = 1'b0;
        if (cap)     vld_d = 1'b1;
    end

    always_comb begin
        pend_o = '0;
        if (live_o) pend_o[addr_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (cap) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load writeback.
// Define REGFILE_WARB_STATS_EN to enable the per-requester saturating stall counters.
module regfile_wport_arbiter
    import regfile_warb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wport_arbiter_if.slave bus
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [NUM_REQ-1:0] val, rdy, vld, live, grant;
    logic [ADDR_W-1:0]  addr_in   [NUM_REQ];
    logic [DATA_W-1:0]  data_in   [NUM_REQ];
    logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
    logic [DATA_W-1:0]  slot_data [NUM_REQ];
    logic [NREG-1:0]    pend      [NUM_REQ];
    logic               ptr_q, ptr_d;

    assign val        = {bus.req1_val, bus.req0_val};
    assign addr_in[0] = bus.req0_addr;
    assign addr_in[1] = bus.req1_addr;
    assign data_in[0] = bus.req0_data;
    assign data_in[1] = bus.req1_data;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
        regfile_warb_slot #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .val_i   (val[k]),
            .addr_i  (addr_in[k]),
            .data_i  (data_in[k]),
            .grant_i (grant[k]),
            .rdy_o   (rdy[k]),
            .vld_o   (vld[k]),
            .live_o  (live[k]),
            .addr_o  (slot_addr[k]),
            .data_o  (slot_data[k]),
            .pend_o  (pend[k])
        );
    end

    // Grant depends on slot state only; ptr names the preferred slot under contention.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        if (vld[0] && (!vld[1] || !ptr_q)) begin
            grant[0] = 1'b1;
            ptr_d    = 1'b1;
        end else if (vld[1]) begin
            grant[1] = 1'b1;
            ptr_d    = 1'b0;
        end
    end

    always_comb begin
        bus.wen   = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        if (grant[0]) begin
            bus.wen   = live[0];
            bus.waddr = slot_addr[0];
            bus.wdata = slot_data[0];
        end else if (grant[1]) begin
            bus.wen   = live[1];
            bus.waddr = slot_addr[1];
            bus.wdata = slot_data[1];
        end
    end

    assign bus.req0_rdy = rdy[0];
    assign bus.req1_rdy = rdy[1];
    assign bus.pend     = pend[0] | pend[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

`ifdef REGFILE_WARB_STATS_EN
    logic [CNT_W-1:0] stall_q [NUM_REQ];
    logic [CNT_W-1:0] stall_d [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            stall_d[k] = stall_q[k];
            if (val[k] && !rdy[k] && (stall_q[k] != {CNT_W{1'b1}})) begin
                stall_d[k] = stall_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REQ; k++) stall_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) stall_q[k] <= stall_d[k];
        end
    end

    assign bus.stall0_cnt = stall_q[0];
    assign bus.stall1_cnt = stall_q[1];
`else
    assign bus.stall0_cnt = {CNT_W{1'b0}};
    assign bus.stall1_cnt = {CNT_W{1'b0}};
`endif

endmodule
